// File: rtl/mux_ctrl_pkg.sv
// Shared definitions for the 8-way round-robin mux arbiter.
//   N_REQ   : number of requesters sharing the 8:1 mux path
//   SEL_W   : width of the encoded mux select
//   state_t : arbiter FSM states (IDLE = path free, GRANT = path owned)
//   onehot  : encoded index -> one-hot grant vector
package mux_ctrl_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin winner search over 8 requesters.
// Ports:
//   req  [7:0] in  : request vector, bit i = requester i
//   last [2:0] in  : most recently granted requester
//   any        out : at least one request is pending
//   win  [2:0] out : first requester set when scanning last+1 .. last+8 (mod 8)
module rr_pick8
  import mux_ctrl_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             any,
  output logic [SEL_W-1:0] win
);

  logic [SEL_W-1:0] start;
  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] ofs;
  logic             found;

  always_comb begin
    // Search begins one past the previous owner; 3-bit adds wrap 7 -> 0.
    start = last + SEL_W'(1);
    // rot[0] is the requester at 'start', rot[7] the previous owner itself.
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[SEL_W'(i) + start];
    end
    ofs   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && rot[i]) begin
        ofs   = SEL_W'(i);
        found = 1'b1;
      end
    end
    any = |req;
    win = ofs + start;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the select of an 8:1 mux shared by 8 requesters.
// The owner keeps the path until it pulses done, drops its request, or has held
// it for MAX_HOLD cycles (0 disables the limit). Every ownership change passes
// through one IDLE cycle so the mux select settles before the next grant.
// Ports:
//   clk            in  : rising-edge clock
//   rst_n          in  : asynchronous active-low reset
//   req       [7:0] in : level request per requester
//   done           in  : owner release pulse (ignored while idle)
//   gnt       [7:0] out: registered one-hot grant, zero when idle
//   sel       [2:0] out: registered encoded grant, drives the mux select
//   gnt_valid      out : a grant is held, mux output is meaningful
//   timeout        out : one-cycle pulse when an owner is cut off by the hold limit
module mux8_rr_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam bit           HOLD_LIMITED = (MAX_HOLD > 0);
  localparam int           HC_W         = HOLD_LIMITED ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HOLD_LIMITED ? HC_W'(MAX_HOLD - 1) : '0;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [SEL_W-1:0] last_q, last_d;

  logic             pick_any;
  logic [SEL_W-1:0] pick_win;
  logic             rel_done, rel_drop, rel_limit, release_now;

  rr_pick8 u_pick (
    .req  (req),
    .last (last_q),
    .any  (pick_any),
    .win  (pick_win)
  );

  // State and output registers. last resets to 7 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      sel_q       <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      hold_cnt_q  <= '0;
      last_q      <= SEL_W'(N_REQ - 1);
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      sel_q       <= sel_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      hold_cnt_q  <= hold_cnt_d;
      last_q      <= last_d;
    end
  end

  // Next-state logic. Release causes are only consulted while a grant is held.
  always_comb begin
    rel_done    = done;
    rel_drop    = ~req[sel_q];
    rel_limit   = HOLD_LIMITED && (hold_cnt_q == HOLD_LAST);
    release_now = rel_done | rel_drop | rel_limit;

    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any)    state_d = GRANT;
      GRANT:   if (release_now) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Register inputs for the outputs, pointer and hold counter.
  always_comb begin
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    hold_cnt_d  = hold_cnt_q;
    last_d      = last_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d       = onehot(pick_win);
          sel_d       = pick_win;
          gnt_valid_d = 1'b1;
          last_d      = pick_win;
          hold_cnt_d  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          // sel is left alone so the mux select does not move while idle.
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          // A cut-off is only flagged when the limit is the sole reason.
          timeout_d   = rel_limit & ~rel_done & ~rel_drop;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d  = hold_cnt_q + HC_W'(1);
        end
      end
      default: begin
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       gnt_valid;
  logic       timeout;

  // 8:1 bit mux driven by the arbiter select
  logic [7:0] mux_d;
  logic       mux_o;
  assign mux_d = 8'h59;
  assign mux_o = mux_d[sel];

  int n_assert = 0;
  int n_fail   = 0;

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .sel       (sel),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx);
    logic [7:0] pat;
    pat = 8'h59;
    check({tag, " gnt"}, 32'(gnt), 32'(8'h01 << idx));
    check({tag, " sel"}, 32'(sel), 32'(idx));
    check({tag, " valid"}, 32'(gnt_valid), 32'd1);
    check({tag, " o"}, 32'(mux_o), 32'(pat[idx]));
  endtask

  task automatic check_idle(input string tag, input logic exp_to);
    check({tag, " idle gnt"}, 32'(gnt), 32'h0);
    check({tag, " idle valid"}, 32'(gnt_valid), 32'd0);
    check({tag, " timeout"}, 32'(timeout), 32'(exp_to));
  endtask

  initial begin
    // Reset with all requests pending
    rst_n = 1'b0;
    req   = 8'hFF;
    done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst gnt", 32'(gnt), 32'h0);
    check("rst sel", 32'(sel), 32'h0);
    check("rst valid", 32'(gnt_valid), 32'd0);
    check("rst timeout", 32'(timeout), 32'd0);
    rst_n = 1'b1;
    tick();
    check_grant("first", 3'd0);

    // Full rotation with done one cycle into each grant
    for (int k = 0; k <= 8; k++) begin
      check_grant($sformatf("rot%0d", k), 3'(k % 8));
      done = 1'b1;
      if (k == 8) req = 8'h00;
      tick();
      check_idle($sformatf("rot%0d", k), 1'b0);
      check($sformatf("rot%0d sel kept", k), 32'(sel), 32'(k % 8));
      done = 1'b0;
      if (k < 8) tick();
    end
    tick();
    check("rot end gnt", 32'(gnt), 32'h0);

    // Hold limit: requester 2 cut off after 4 cycles, then 5 served
    req = 8'h24;
    tick();
    for (int c = 0; c < 4; c++) begin
      check($sformatf("hold c%0d gnt", c), 32'(gnt), 32'h04);
      check($sformatf("hold c%0d timeout", c), 32'(timeout), 32'd0);
      tick();
    end
    check_idle("hold end", 1'b1);
    tick();
    check_grant("after hold", 3'd5);
    check("after hold timeout", 32'(timeout), 32'd0);

    // Single requester 7: drop of req[5] releases 5 without timeout
    req = 8'h80;
    tick();
    check_idle("drop5", 1'b0);
    tick();
    check_grant("solo7 a", 3'd7);
    repeat (3) tick();
    check("solo7 a c3 gnt", 32'(gnt), 32'h80);
    tick();
    check_idle("solo7 a end", 1'b1);
    tick();
    check_grant("solo7 b", 3'd7);
    // done coincident with the hold limit is a normal release
    repeat (3) tick();
    done = 1'b1;
    tick();
    check_idle("done+limit", 1'b0);
    done = 1'b0;
    tick();
    check_grant("solo7 c", 3'd7);

    // Owner 3 drops its request while 5 waits
    req = 8'h08;
    tick();
    check_idle("to3", 1'b0);
    tick();
    check_grant("own3", 3'd3);
    tick();
    check("own3 held", 32'(gnt), 32'h08);
    req = 8'h20;
    tick();
    check_idle("drop3", 1'b0);
    check("drop3 sel kept", 32'(sel), 32'd3);
    tick();
    check_grant("own5", 3'd5);

    // Asynchronous reset while requester 6 owns the path
    req = 8'h40;
    tick();
    check_idle("to6", 1'b0);
    tick();
    check_grant("own6", 3'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst gnt", 32'(gnt), 32'h0);
    check("async rst sel", 32'(sel), 32'h0);
    check("async rst valid", 32'(gnt_valid), 32'd0);
    req = 8'hC1;
    tick();
    check("held rst gnt", 32'(gnt), 32'h0);
    rst_n = 1'b1;
    tick();
    check_grant("post rst", 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
